// File: rtl/div_32bit.sv
// Iterative radix-2 restoring divider with RV32M DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle, valid/ready request handshake, result held until acknowledged.
module div_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             ready_o,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             result_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, div_mag;
  logic             neg_q, neg_r;

  logic             div_zero, overflow, last;
  logic [WIDTH-1:0] a_mag, b_mag, rem_next, quo_next;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    div_zero = (b_i == '0);
    overflow = signed_i && (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
    a_mag    = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag    = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    last     = (count == CW'(WIDTH-1));
  end

  // A negative trial difference (MSB of the WIDTH+1-bit result) means restore.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, div_mag};
    rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_i) state_next = (div_zero || overflow) ? DONE : CALC;
      CALC: if (last)    state_next = DONE;
      DONE: if (result_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
    valid_o = (state == DONE);
    busy_o  = (state == CALC) || (state == DONE);
  end

  // Special cases resolve at accept; the last iteration applies the sign fix-up directly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      div_mag     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (div_zero) begin
              quotient_o  <= '1;
              remainder_o <= a_i;
            end else if (overflow) begin
              quotient_o  <= {1'b1, {(WIDTH-1){1'b0}}};
              remainder_o <= '0;
            end else begin
              count   <= '0;
              rem     <= '0;
              quo     <= a_mag;
              div_mag <= b_mag;
              neg_q   <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              neg_r   <= signed_i && a_i[WIDTH-1];
            end
          end
        end
        CALC: begin
          count <= count + 1'b1;
          rem   <= rem_next;
          quo   <= quo_next;
          if (last) begin
            quotient_o  <= neg_q ? -quo_next : quo_next;
            remainder_o <= neg_r ? -rem_next : rem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32bit.sv
// Directed self-checking bench for div_32bit: sign rules, special cases, latency,
// handshake misuse and asynchronous reset during a calculation.
module tb_div_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        result_ready = 1'b0;
  logic        ready_o, valid_o, busy_o;
  logic [31:0] quotient_o, remainder_o;

  int vectors = 0;
  int miscompares = 0;

  div_32bit #(.WIDTH(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .ready_o        (ready_o),
    .signed_i       (sgn),
    .a_i            (a_i),
    .b_i            (b_i),
    .valid_o        (valid_o),
    .result_ready_i (result_ready),
    .quotient_o     (quotient_o),
    .remainder_o    (remainder_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Returns one negedge after the accept edge, with operands scrambled.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    int guard = 0;
    while (!ready_o && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1;
    a_i = a;
    b_i = b;
    sgn = s;
    @(negedge clk);
    start = 1'b0;
    a_i = ~a;
    b_i = ~b;
    sgn = ~s;
  endtask

  task automatic waitValid(output int lat);
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ackResult(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput({tag, ".valid_after_ack"}, 32'(valid_o), 32'd0);
    checkOutput({tag, ".ready_after_ack"}, 32'(ready_o), 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] exp_q, input logic [31:0] exp_r, input int exp_lat);
    int lat;
    applyStimulus(a, b, s);
    waitValid(lat);
    checkOutput({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, ".q"}, quotient_o, exp_q);
    checkOutput({tag, ".r"}, remainder_o, exp_r);
    checkOutput({tag, ".ready"}, 32'(ready_o), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy_o), 32'd1);
    ackResult(tag);
  endtask

  initial begin
    int lat;
    int seen;

    #3;
    checkOutput("reset.ready", 32'(ready_o), 32'd1);
    checkOutput("reset.valid", 32'(valid_o), 32'd0);
    checkOutput("reset.busy", 32'(busy_o), 32'd0);
    checkOutput("reset.q", quotient_o, 32'd0);
    checkOutput("reset.r", remainder_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned basic with the result held for five cycles before the ack.
    applyStimulus(32'd100, 32'd7, 1'b0);
    waitValid(lat);
    checkOutput("u100_7.latency", 32'(lat), 32'd33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("u100_7.hold_valid", 32'(valid_o), 32'd1);
      checkOutput("u100_7.hold_q", quotient_o, 32'd14);
      checkOutput("u100_7.hold_r", remainder_o, 32'd2);
    end
    ackResult("u100_7");

    runOp("s_m7_2",   32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    runOp("s_7_m2",   32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         33);
    runOp("s_m100_m7",32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE, 33);
    runOp("s_m6_3",   32'hFFFF_FFFA, 32'd3,         1'b1, 32'hFFFF_FFFE, 32'd0,         33);
    runOp("dz_s",     32'h1234_5678, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1);
    runOp("dz_u",     32'h1234_5678, 32'd0,         1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1);
    runOp("ovf_s",    32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1);
    runOp("ovf_u",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 33);
    runOp("max_1",    32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0,         33);

    // Start pulses with other operands during CALC must be ignored.
    applyStimulus(32'd1000, 32'd3, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    a_i = 32'd50;
    b_i = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("calc_start.ready", 32'(ready_o), 32'd0);
    end
    start = 1'b0;
    waitValid(lat);
    checkOutput("calc_start.q", quotient_o, 32'd333);
    checkOutput("calc_start.r", remainder_o, 32'd1);
    ackResult("calc_start");

    // Back-to-back: a request present on the ack edge is taken only on the next edge.
    applyStimulus(32'd20, 32'd6, 1'b0);
    waitValid(lat);
    checkOutput("b2b_first.q", quotient_o, 32'd3);
    checkOutput("b2b_first.r", remainder_o, 32'd2);
    result_ready = 1'b1;
    start = 1'b1;
    a_i = 32'd81;
    b_i = 32'd9;
    sgn = 1'b0;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput("b2b.ack_edge_valid", 32'(valid_o), 32'd0);
    checkOutput("b2b.ack_edge_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    start = 1'b0;
    a_i = 32'd7;
    b_i = 32'd0;
    checkOutput("b2b.accepted_busy", 32'(busy_o), 32'd1);
    waitValid(lat);
    checkOutput("b2b_second.latency", 32'(lat), 32'd33);
    checkOutput("b2b_second.q", quotient_o, 32'd9);
    checkOutput("b2b_second.r", remainder_o, 32'd0);
    ackResult("b2b_second");

    // Ack held high before completion: DONE lasts a single cycle.
    applyStimulus(32'd52, 32'd5, 1'b0);
    result_ready = 1'b1;
    waitValid(lat);
    checkOutput("early_ack.latency", 32'(lat), 32'd33);
    checkOutput("early_ack.q", quotient_o, 32'd10);
    checkOutput("early_ack.r", remainder_o, 32'd2);
    @(negedge clk);
    checkOutput("early_ack.valid_drop", 32'(valid_o), 32'd0);
    checkOutput("early_ack.ready", 32'(ready_o), 32'd1);
    result_ready = 1'b0;

    // Asynchronous reset in the middle of a calculation.
    applyStimulus(32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst.valid", 32'(valid_o), 32'd0);
    checkOutput("midrst.ready", 32'(ready_o), 32'd1);
    checkOutput("midrst.busy", 32'(busy_o), 32'd0);
    checkOutput("midrst.q", quotient_o, 32'd0);
    checkOutput("midrst.r", remainder_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    checkOutput("midrst.no_valid_pulse", 32'(seen), 32'd0);
    runOp("post_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_32bit.md
Name: div_32bit

Overview:
- Iterative radix-2 restoring divider for the CPU execute stage; the multi-cycle counterpart to the single-cycle bitwise/arithmetic units.
- Implements RV32M DIV/DIVU/REM/REMU semantics.
- Accepts one operation through a valid/ready request handshake and holds the result until the consumer acknowledges it.

Parameters:
- WIDTH, 32, operand and result width in bits; the iteration count equals WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request valid.
- ready_o  output  1  divider idle, can accept a request.
- signed_i  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled at accept.
- a_i  input  WIDTH  dividend; sampled at accept.
- b_i  input  WIDTH  divisor; sampled at accept.
- valid_o  output  1  quotient_o/remainder_o are valid.
- result_ready_i  input  1  consumer acknowledges the result.
- quotient_o  output  WIDTH  quotient.
- remainder_o  output  WIDTH  remainder.
- busy_o  output  1  high in CALC and DONE.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, ready_o=1, valid_o=0, busy_o=0, quotient_o=0, remainder_o=0, iteration counter=0.
- States:
  - IDLE: ready_o=1. Accept occurs on an edge with start_i=1. At accept, latch signed_i and the operands.
    - If b_i==0: next state DONE.
    - If signed_i=1, a_i=0x8000_0000 and b_i=0xFFFF_FFFF: next state DONE.
    - Otherwise: next state CALC, counter=0.
  - CALC: one quotient bit per edge, MSB first.
    - Shift the remainder:dividend pair left by 1.
    - Trial-subtract the magnitude of the divisor using a WIDTH+1-bit subtractor.
    - Keep the difference if non-negative and shift in 1; otherwise restore and shift in 0.
    - After the WIDTH-th iteration (counter==WIDTH-1): apply sign fix-up in the same edge, then go to DONE.
  - DONE: valid_o=1 and outputs stable. On an edge with result_ready_i=1: go to IDLE, valid_o=0. Outputs keep their last value after leaving DONE.
- Signed handling: operands are converted to magnitudes at accept.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - A zero remainder stays zero.
- Special results:
  - Divide by zero: quotient = all ones (0xFFFF_FFFF), remainder = a_i, for both signed and unsigned.
  - Signed overflow (0x8000_0000 / -1): quotient = 0x8000_0000, remainder = 0.
- Latency: normal operation has valid_o high after the 32nd edge following the accept edge. Special cases have valid_o high after the accept edge (1 cycle).
- Throughput: one operation in flight.
  - ready_o=0 in CALC and DONE.
  - start_i outside IDLE is ignored; no queueing, no error.
  - A new request can be accepted in the cycle after the DONE→IDLE edge. No same-edge DONE→accept bypass.
- Operand changes on a_i/b_i/signed_i after the accept edge have no effect.
- Reset mid-CALC or mid-DONE: immediate return to the reset state. The in-flight result is discarded and valid_o never pulses for it.
- result_ready_i held high before completion: DONE lasts exactly one cycle. valid_o is still high for one full cycle.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Unsigned basic: a=100, b=7, signed=0 → after 32 edges, quotient=14, remainder=2, valid_o=1. Holds while result_ready_i=0 for 5 cycles, then clears one edge after result_ready_i=1.
2. Signed sign rules: a=-7 (0xFFFF_FFF9), b=2 → q=-3 (0xFFFF_FFFD), r=-1 (0xFFFF_FFFF). Then a=7, b=-2 → q=-3, r=1.
3. Divide by zero: a=0x1234_5678, b=0, signed and unsigned → valid_o one edge after accept, q=0xFFFF_FFFF, r=0x1234_5678.
4. Overflow and near-edge cases:
   - a=0x8000_0000, b=0xFFFF_FFFF, signed=1 → 1-cycle result, q=0x8000_0000, r=0.
   - Same operands with signed=0 → 32-cycle result, q=0, r=0x8000_0000.
   - a=0xFFFF_FFFF, b=1, unsigned → q=0xFFFF_FFFF, r=0.
5. Handshake abuse:
   - Assert start_i with different operands during CALC → ignored; the original result is returned and ready_o stays 0.
   - Back-to-back requests: second accepted only in the cycle after the ack edge.
6. Async reset: assert rst_i at iteration 15 of a=1000, b=3, between clock edges → outputs go to reset values immediately, with no valid_o pulse. A fresh a=9, b=3 afterwards returns q=3, r=0.
